psum_requant: RTL and testbench

//  Downstream of kernel_mac: accumulates per-lane MAC outputs over a group of beats
//  (one output pixel / channel tile), then requantizes each lane to OP_WIDTH with

---
 rtl/psum_requant.sv | 178 +++++++++++++++++
 tb/tb_psum_requant.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/psum_requant.sv
// psum_requant: per-lane group accumulation of kernel_mac outputs, then
// round / shift / ReLU / saturate to OP_WIDTH and queue in a small FIFO.
// Input is never backpressured; results that find the FIFO full are dropped.

// One lane: saturating group accumulator, last-beat stage register and the
// combinational requantizer that reads the stage register.
module psum_requant_lane #(
  parameter int OP_WIDTH  = 8,
  parameter int ACC_WIDTH = 20,
  parameter int SUM_WIDTH = 24,
  parameter int SHIFT_W   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic                 accum,
  input  logic [ACC_WIDTH-1:0] psum,
  input  logic [SHIFT_W-1:0]   st_shift,
  input  logic                 st_relu,
  output logic [OP_WIDTH-1:0]  res
);
  // wide enough that the rounding constant for any shift cannot overflow
  localparam int RW = SUM_WIDTH + (1 << SHIFT_W) + 1;
  localparam logic signed [SUM_WIDTH-1:0] SMAX = {1'b0, {(SUM_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_WIDTH-1:0] SMIN = {1'b1, {(SUM_WIDTH-1){1'b0}}};
  localparam logic signed [RW-1:0] OMAX = (RW'(1) << (OP_WIDTH-1)) - RW'(1);
  localparam logic signed [RW-1:0] OMIN = -(RW'(1) << (OP_WIDTH-1));

  logic signed [SUM_WIDTH-1:0] acc, stg, base, ext, sum_nxt;
  logic signed [SUM_WIDTH:0]   wide;
  logic signed [RW-1:0]        ext_r, rnd, shf;

  // first beat of a group starts from zero; later beats add to acc with clamp
  always_comb begin
    base    = accum ? acc : '0;
    ext     = SUM_WIDTH'($signed(psum));
    wide    = {base[SUM_WIDTH-1], base} + {ext[SUM_WIDTH-1], ext};
    sum_nxt = wide[SUM_WIDTH-1:0];
    if (wide[SUM_WIDTH] != wide[SUM_WIDTH-1])
      sum_nxt = wide[SUM_WIDTH] ? SMIN : SMAX;
  end

  // accumulate middle beats; the last beat's sum goes to the stage register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      stg <= '0;
    end else if (in_valid) begin
      if (in_last) stg <= sum_nxt;
      else         acc <= sum_nxt;
    end
  end

  // round-half-up arithmetic shift, optional ReLU, saturate to OP_WIDTH
  always_comb begin
    ext_r = RW'(stg);
    rnd   = '0;
    if (st_shift != '0) rnd = RW'(1) << (st_shift - SHIFT_W'(1));
    shf   = (ext_r + rnd) >>> st_shift;
    if (st_relu && shf < 0) shf = '0;
    if (shf > OMAX)      res = OMAX[OP_WIDTH-1:0];
    else if (shf < OMIN) res = OMIN[OP_WIDTH-1:0];
    else                 res = shf[OP_WIDTH-1:0];
  end
endmodule

module psum_requant #(
  parameter int OP_WIDTH   = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int LANES      = 1,
  parameter int SUM_WIDTH  = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int SHIFT_W    = 5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic                                in_last,
  input  logic [0:LANES-1][ACC_WIDTH-1:0]     in_psums,
  input  logic [SHIFT_W-1:0]                  cfg_shift,
  input  logic                                cfg_relu,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [0:LANES-1][OP_WIDTH-1:0]      out_data,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_count,
  output logic                                busy,
  output logic                                overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state, state_nxt;

  logic                             st_vld, st_relu;
  logic [SHIFT_W-1:0]               st_shift;
  logic [0:LANES-1][OP_WIDTH-1:0]   st_res;

  logic [0:LANES-1][OP_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]                    wptr, rptr;
  logic                             full, pop, push;

  // group state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // enter ACCUM on a non-last beat, leave on the last beat; no timeout
  always_comb begin
    state_nxt = state;
    if (in_valid) state_nxt = in_last ? IDLE : ACCUM;
  end

  assign busy = (state == ACCUM);

  // stage valid and the cfg values that travel with the last beat
  always_ff @(posedge clk) begin
    if (rst) begin
      st_vld   <= 1'b0;
      st_shift <= '0;
      st_relu  <= 1'b0;
    end else begin
      st_vld <= in_valid & in_last;
      if (in_valid & in_last) begin
        st_shift <= cfg_shift;
        st_relu  <= cfg_relu;
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    psum_requant_lane #(
      .OP_WIDTH (OP_WIDTH),
      .ACC_WIDTH(ACC_WIDTH),
      .SUM_WIDTH(SUM_WIDTH),
      .SHIFT_W  (SHIFT_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .in_valid(in_valid),
      .in_last (in_last),
      .accum   (state == ACCUM),
      .psum    (in_psums[l]),
      .st_shift(st_shift),
      .st_relu (st_relu),
      .res     (st_res[l])
    );
  end

  assign out_valid = (fifo_count != '0);
  assign out_data  = mem[rptr];
  assign full      = (fifo_count == CW'(FIFO_DEPTH));
  assign pop       = out_valid & out_ready;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign push      = st_vld & (~full | pop);

  // output FIFO; storage is cleared on reset so out_data reads 0 when empty
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= st_res;
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      if (push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (pop && !push) fifo_count <= fifo_count - CW'(1);
      if (st_vld && !push) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_psum_requant.sv
// Directed bench for psum_requant with LANES=2; expected values hand-computed.
module tb_psum_requant;
  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_last;
  logic [0:1][19:0]  in_psums;
  logic [4:0]        cfg_shift;
  logic              cfg_relu;
  logic              out_valid, out_ready;
  logic [0:1][7:0]   out_data;
  logic [2:0]        fifo_count;
  logic              busy, overflow;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  psum_requant #(.LANES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_psums  (in_psums),
    .cfg_shift (cfg_shift),
    .cfg_relu  (cfg_relu),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .fifo_count(fifo_count),
    .busy      (busy),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // present one beat for one cycle; returns #1 after the capturing edge
  task automatic beat(input int v0, input int v1, input bit last,
                      input int sh, input bit relu);
    in_valid    = 1'b1;
    in_last     = last;
    in_psums[0] = 20'(v0);
    in_psums[1] = 20'(v1);
    cfg_shift   = 5'(sh);
    cfg_relu    = relu;
    @(posedge clk); #1;
    in_valid    = 1'b0;
    in_last     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // wait (bounded) for the head, check both lanes, then pop it
  task automatic pop_chk(input string tag, input int e0, input int e1);
    int n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk({tag, "_vld"}, int'(out_valid), 1);
    chk({tag, "_l0"}, int'($signed(out_data[0])), e0);
    chk({tag, "_l1"}, int'($signed(out_data[1])), e1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_last = 0; in_psums = '0;
    cfg_shift = 0; cfg_relu = 0; out_ready = 0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_vld",   int'(out_valid), 0);
    chk("rst_data",  int'(out_data), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_ovf",   int'(overflow), 0);

    // 1: four-beat group, latency check
    beat(10, -3, 0, 0, 0);
    chk("t1_busy", int'(busy), 1);
    beat(20, -3, 0, 0, 0);
    beat(30, -3, 0, 0, 0);
    beat(40, -3, 1, 0, 0);
    chk("t1_lat1", int'(out_valid), 0);
    tick();
    chk("t1_lat2", int'(out_valid), 1);
    pop_chk("t1", 100, -12);

    // 2: single-beat groups with shift, relu, output saturation
    beat(1000, 1020, 1, 3, 0);
    pop_chk("t2a", 125, 127);
    beat(-1100, -1100, 1, 3, 1);
    pop_chk("t2b", 0, 0);
    beat(-1100, -1100, 1, 3, 0);
    pop_chk("t2c", -128, -128);

    // 3: rounding
    beat(-5, 5, 1, 1, 0);
    pop_chk("t3a", -2, 3);
    beat(7, -7, 1, 0, 0);
    pop_chk("t3b", 7, -7);

    // 4: five back-to-back groups into a 4-deep FIFO with no consumer
    for (int i = 1; i <= 5; i++) beat(i, -i, 1, 0, 0);
    chk("t4_cnt4",  int'(fifo_count), 4);
    chk("t4_ovf0",  int'(overflow), 0);
    tick();
    chk("t4_cnt",   int'(fifo_count), 4);
    chk("t4_ovf1",  int'(overflow), 1);
    for (int i = 1; i <= 4; i++) pop_chk($sformatf("t4_d%0d", i), i, -i);
    chk("t4_empty", int'(fifo_count), 0);
    chk("t4_stick", int'(overflow), 1);

    // 4b: full FIFO, push and pop in the same cycle
    do_reset();
    chk("t4b_ovfclr", int'(overflow), 0);
    for (int i = 11; i <= 15; i++) beat(i, i + 50, 1, 0, 0);
    chk("t4b_full", int'(fifo_count), 4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t4b_cnt", int'(fifo_count), 4);
    chk("t4b_ovf", int'(overflow), 0);
    for (int i = 12; i <= 15; i++) pop_chk($sformatf("t4b_d%0d", i), i, i + 50);

    // 5: accumulator saturation in both directions
    for (int i = 0; i < 19; i++) beat(524287, -524288, 0, 0, 0);
    beat(524287, -524288, 1, 16, 0);
    pop_chk("t5", 127, -128);

    // 6: reset in the middle of a group
    beat(100, 100, 0, 0, 0);
    beat(100, 100, 0, 0, 0);
    in_valid = 1'b1; in_psums[0] = 20'd100; in_psums[1] = 20'd100;
    rst = 1'b1;
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    chk("t6_busy", int'(busy), 0);
    chk("t6_cnt",  int'(fifo_count), 0);
    chk("t6_vld",  int'(out_valid), 0);
    beat(5, 6, 0, 0, 0);
    beat(1, 1, 1, 0, 0);
    pop_chk("t6", 6, 7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
